button_event_gen: RTL and testbench

- Sits directly downstream of the LED-path debouncer and consumes its clean 1-bit level.
- Converts that level into single-cycle event strobes that drive the counter datapath: press, release, long-press and auto-repeat.
- A small FSM plus one hold-time counter; all outputs are registered.

---
 rtl/button_event_gen.sv | 123 ++++++++++++
 tb/tb_button_event_gen.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long/repeat strobes.
// Optional press counter output enabled by BUTTON_EVENT_PRESS_COUNT_EN.
module button_event_gen #(
    parameter int                   CNT_WIDTH     = 16,
    parameter logic [CNT_WIDTH-1:0] LONG_CYCLES   = 16'd50000,
    parameter logic [CNT_WIDTH-1:0] REPEAT_CYCLES = 16'd10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_in,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
`ifdef BUTTON_EVENT_PRESS_COUNT_EN
    output logic [7:0] press_count,
`endif
    output logic       held
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_CYCLES - 1'b1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_TC = CNT_WIDTH'(REPEAT_CYCLES - 1'b1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_prev_level;
    logic                 w_rise;

    assign w_rise = level_in & ~r_prev_level;

    // prev_level resets to 1 so a button held through reset is not a press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_prev_level  <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            r_prev_level  <= level_in;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                held    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (w_rise) begin
                            press_pulse <= 1'b1;
                            r_state     <= PRESS;
                            held        <= 1'b1;
                        end else begin
                            held <= 1'b0;
                        end
                    end
                    PRESS: begin
                        if (!level_in) begin
                            release_pulse <= 1'b1;
                            r_state       <= IDLE;
                            r_cnt         <= '0;
                            held          <= 1'b0;
                        end else if (r_cnt == LONG_TC) begin
                            long_pulse <= 1'b1;
                            r_state    <= REPEAT;
                            r_cnt      <= '0;
                            held       <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            held  <= 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!level_in) begin
                            release_pulse <= 1'b1;
                            r_state       <= IDLE;
                            r_cnt         <= '0;
                            held          <= 1'b0;
                        end else if (r_cnt == REPEAT_TC) begin
                            repeat_pulse <= 1'b1;
                            r_cnt        <= '0;
                            held         <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            held  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        held    <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BUTTON_EVENT_PRESS_COUNT_EN
    // Counts accepted presses only; same acceptance condition as press_pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_count <= 8'd0;
        end else if (enable && (r_state == IDLE) && w_rise) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed table-driven bench for button_event_gen (LONG_CYCLES=8, REPEAT_CYCLES=4).
module tb_button_event_gen;

    logic clk = 1'b0;
    logic rst;
    logic level_in;
    logic enable;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
`ifdef BUTTON_EVENT_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    always #5 clk = ~clk;

    button_event_gen #(
        .CNT_WIDTH    (16),
        .LONG_CYCLES  (16'd8),
        .REPEAT_CYCLES(16'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .level_in     (level_in),
        .enable       (enable),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
`ifdef BUTTON_EVENT_PRESS_COUNT_EN
        .press_count  (press_count),
`endif
        .held         (held)
    );

    // expected vector = {press, release, long, repeat, held}
    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] P  = 5'b10001;
    localparam logic [4:0] H  = 5'b00001;
    localparam logic [4:0] R  = 5'b01000;
    localparam logic [4:0] L  = 5'b00101;
    localparam logic [4:0] RP = 5'b00011;

    typedef struct packed {
        logic       lvl;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input logic l, input logic e, input logic [4:0] x);
        vec_t v;
        v.lvl = l;
        v.en  = e;
        v.exp = x;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [4:0] x);
        logic [4:0] act;
        act = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
        checks++;
        if (act !== x) begin
            errors++;
            $display("FAIL %s: got p/r/l/rp/h=%b expected %b", nm, act, x);
        end
    endtask

    task automatic step(input logic l, input logic e, input logic [4:0] x, input string nm);
        level_in = l;
        enable   = e;
        @(posedge clk);
        #1;
        chk(nm, x);
    endtask

    initial begin
        // held through reset, then released: never a press
        repeat (20) add(1, 1, Z);
        add(0, 1, Z); add(0, 1, Z);
        // short press of 3 cycles
        add(1, 1, P); add(1, 1, H); add(1, 1, H); add(0, 1, R); add(0, 1, Z);
        // 30-cycle hold: long at +8, repeats at +12..+28
        for (int k = 0; k < 30; k++)
            add(1, 1, (k == 0) ? P : (k == 8) ? L : (k >= 12 && k % 4 == 0) ? RP : H);
        add(0, 1, R); add(0, 1, Z);
        // release on the PRESS terminal-count edge
        for (int k = 0; k < 8; k++) add(1, 1, (k == 0) ? P : H);
        add(0, 1, R); add(0, 1, Z);
        // release on the REPEAT terminal-count edge
        for (int k = 0; k < 16; k++)
            add(1, 1, (k == 0) ? P : (k == 8) ? L : (k == 12) ? RP : H);
        add(0, 1, R); add(0, 1, Z);
        // enable dropped in REPEAT, restored while held
        for (int k = 0; k < 10; k++) add(1, 1, (k == 0) ? P : (k == 8) ? L : H);
        add(1, 0, Z); add(1, 0, Z);
        repeat (4) add(1, 1, Z);
        add(0, 1, Z);
        add(1, 1, P); add(1, 1, H); add(0, 1, R); add(0, 1, Z);
        // rise while disabled is not remembered
        add(1, 0, Z); add(1, 1, Z); add(0, 1, Z);

        rst      = 1'b0;
        level_in = 1'b1;
        enable   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", Z);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].lvl, tbl[i].en, tbl[i].exp, $sformatf("vec%0d", i));

        // asynchronous reset mid-hold
        step(1, 1, P, "mr_press");
        step(1, 1, H, "mr_hold");
        #2 rst = 1'b0;
        #1 chk("mr_async_drop", Z);
`ifdef BUTTON_EVENT_PRESS_COUNT_EN
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL mr_count_reset: got %0d expected 0", press_count);
        end
`endif
        @(posedge clk);
        #1 chk("mr_in_reset", Z);
        rst = 1'b1;
        step(1, 1, Z, "mr_after_held");
        step(0, 1, Z, "mr_after_fall");

`ifdef BUTTON_EVENT_PRESS_COUNT_EN
        for (int n = 0; n < 257; n++) begin
            step(1, 1, P, $sformatf("cnt_press%0d", n));
            step(0, 1, R, $sformatf("cnt_rel%0d", n));
        end
        checks++;
        if (press_count !== 8'd1) begin
            errors++;
            $display("FAIL press_count_wrap: got %0d expected 1", press_count);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
